abro_fsm: RTL and testbench

- Synchronous Moore controller implementing the classic ABRO (Await A, await B, emit O, Reset) behaviour.
- It waits until both inputs A and B have been seen high, in either order or together, then asserts O.
- It then stays in the done state until the next reset. Sub-sequent A/B activity is ignored.
- It sits at the edge of control logic: A/B come from upstream event sources, O drives a downstream "both events seen" flag, and `state` is exported for debug and observation.

---
 rtl/abro_pkg.sv | 25 ++
 rtl/abro_fsm.sv | 78 +++++++
 tb/tb_abro_fsm.sv | 135 +++++++++++++
 3 files changed

// File: rtl/abro_pkg.sv
// ----------------------------------------------------------------------------
// abro_pkg
// Shared types and helpers for the ABRO controller.
//   abro_state_e   : 4-bit one-hot state encoding (ST_IDLE/ST_GOT_A/ST_GOT_B/ST_DONE)
//   STATE_W        : width of the exported state vector
//   is_legal_state : true when exactly one bit of a state value is set
// ----------------------------------------------------------------------------
package abro_pkg;

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 4'b0001,  // neither A nor B captured
        ST_GOT_A = 4'b0010,  // A captured, waiting for B
        ST_GOT_B = 4'b0100,  // B captured, waiting for A
        ST_DONE  = 4'b1000   // both captured; held until reset
    } abro_state_e;

    // x & (x-1) clears the lowest set bit, so a zero result on a non-zero
    // value means exactly one bit was set.
    function automatic logic is_legal_state(input logic [STATE_W-1:0] s);
        return (s != '0) && ((s & (s - 4'd1)) == '0);
    endfunction

endpackage

// File: rtl/abro_fsm.sv
// ----------------------------------------------------------------------------
// abro_fsm
// Moore ABRO controller: waits until both A and B have been seen high (either
// order, or together), then raises O and stays done until reset.
//
// Ports:
//   clk    in   1  rising-edge clock
//   reset  in   1  asynchronous, active-low reset
//   A      in   1  event A, level-sampled each rising edge
//   B      in   1  event B, level-sampled each rising edge
//   O      out  1  "both seen" flag, registered
//   state  out  4  one-hot state register (debug/observation)
//
// Build option:
//   ABRO_PULSE_EN  defined   -> O pulses for one cycle on entry to DONE
//                  undefined -> O is high for as long as the FSM is in DONE
// ----------------------------------------------------------------------------
module abro_fsm
    import abro_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               A,
    input  logic               B,
    output logic               O,
    output logic [STATE_W-1:0] state
);

    abro_state_e st;
    abro_state_e nxt;

`ifdef ABRO_PULSE_EN
    logic done_q;  // "was in DONE" as of the previous edge
`endif

    assign state = st;

    // Next-state logic. Anything that is not a legal one-hot code falls back
    // to IDLE so an upset state register recovers in one edge.
    always_comb begin
        nxt = ST_IDLE;
        if (is_legal_state(st)) begin
            case (st)
                ST_IDLE: begin
                    if (A && B)  nxt = ST_DONE;
                    else if (A)  nxt = ST_GOT_A;
                    else if (B)  nxt = ST_GOT_B;
                    else         nxt = ST_IDLE;
                end
                ST_GOT_A: nxt = B ? ST_DONE : ST_GOT_A;
                ST_GOT_B: nxt = A ? ST_DONE : ST_GOT_B;
                ST_DONE:  nxt = ST_DONE;
                default:  nxt = ST_IDLE;
            endcase
        end
    end

    // O is registered off the next state so it lines up exactly with the
    // state register (no extra cycle of latency).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st <= ST_IDLE;
            O  <= 1'b0;
`ifdef ABRO_PULSE_EN
            done_q <= 1'b0;
`endif
        end else begin
            st <= nxt;
`ifdef ABRO_PULSE_EN
            done_q <= (nxt == ST_DONE);
            O      <= (nxt == ST_DONE) && !done_q;
`else
            O      <= (nxt == ST_DONE);
`endif
        end
    end

endmodule

// File: tb/tb_abro_fsm.sv
// ----------------------------------------------------------------------------
// tb_abro_fsm
// Directed scenarios followed by random A/B/reset traffic, each checked
// against a reference that only tracks "has A been seen" and "has B been
// seen" since the last reset.
// ----------------------------------------------------------------------------
module tb_abro_fsm;

    logic       clk;
    logic       reset;
    logic       A;
    logic       B;
    logic       O;
    logic [3:0] state;

    int n_chk = 0;
    int n_bad = 0;

    // reference: sticky flags since reset, plus previous "done" for pulse mode
    bit seen_a, seen_b, prev_done;

    abro_fsm dut (
        .clk   (clk),
        .reset (reset),
        .A     (A),
        .B     (B),
        .O     (O),
        .state (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%b exp=%b at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] exp_state();
        if (seen_a && seen_b) return 4'b1000;
        if (seen_a)           return 4'b0010;
        if (seen_b)           return 4'b0100;
        return 4'b0001;
    endfunction

    function automatic logic exp_o();
        bit done = seen_a && seen_b;
`ifdef ABRO_PULSE_EN
        return done && !prev_done;
`else
        return done;
`endif
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".state"}, state, exp_state());
        chk({tag, ".O"}, {3'b0, O}, {3'b0, exp_o()});
    endtask

    // Drive A/B, take one rising edge, update the reference, sample 1ns later.
    task automatic step(input logic a, input logic b, input string tag);
        A = a;
        B = b;
        @(posedge clk);
        prev_done = seen_a && seen_b;
        seen_a    = seen_a | a;
        seen_b    = seen_b | b;
        #1;
        check_all(tag);
    endtask

    // Assert reset away from any clock edge, check it acts immediately,
    // then release well before the next rising edge.
    task automatic do_reset(input string tag);
        #2;
        reset = 1'b0;
        #1;
        seen_a    = 0;
        seen_b    = 0;
        prev_done = 0;
        check_all(tag);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        A = 1'b0;
        B = 1'b0;
        seen_a = 0; seen_b = 0; prev_done = 0;
        #12;
        check_all("por");
        reset = 1'b1;

        // A then B
        repeat (3) step(1'b1, 1'b0, "a_hold");
        step(1'b0, 1'b1, "a_then_b");
        repeat (10) step(1'b0, 1'b0, "done_hold");

        // reset mid-cycle with A=B=1 driven
        A = 1'b1; B = 1'b1;
        do_reset("rst_mid");

        // B then A
        repeat (2) step(1'b0, 1'b1, "b_hold");
        step(1'b1, 1'b0, "b_then_a");
        repeat (10) step($urandom_range(0, 1), $urandom_range(0, 1), "done_ignore");

        // simultaneous on the first edge after release
        do_reset("rst_sim");
        step(1'b1, 1'b1, "simul");
        step(1'b0, 1'b0, "simul_after");

        // A single-cycle pulse is sticky
        do_reset("rst_sticky");
        step(1'b1, 1'b0, "a_pulse");
        repeat (5) step(1'b0, 1'b0, "a_sticky");
        step(1'b0, 1'b1, "sticky_done");
        repeat (20) step($urandom_range(0, 1), $urandom_range(0, 1), "done_rand");
        do_reset("rst_from_done");

        // random traffic with sparse events and occasional resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 29) == 0) do_reset("rnd_rst");
            step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, "rnd");
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
